// File: rtl/irq_controller.sv
// Platform interrupt aggregator: synchronises, latches and masks peripheral
// lines and offers a single-service claim/complete register port.
module irq_controller #(
    parameter int NUM_SOURCES = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SOURCES-1:0] irq_src,
    input  logic                   bus_valid,
    input  logic                   bus_write,
    input  logic [1:0]             bus_addr,
    input  logic [31:0]            bus_wdata,
    output logic                   bus_ready,
    output logic [31:0]            bus_rdata,
    output logic                   ext_int
);
    localparam logic [NUM_SOURCES-1:0] LSB_ONE = NUM_SOURCES'(1'b1);
    localparam logic [NUM_SOURCES-1:0] ALL_ZERO = {NUM_SOURCES{1'b0}};

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RESP = 1'b1} bus_state_t;

    bus_state_t state_r, state_nxt_s;

    logic [NUM_SOURCES-1:0] s1_r, s2_r, s2_d_r;
    logic [NUM_SOURCES-1:0] pending_r, enable_r, edge_mode_r;
    logic                   busy_r;
    logic [4:0]             claimed_id_r;
    logic                   bus_ready_r, ext_int_r;
    logic [31:0]            bus_rdata_r;

    logic [NUM_SOURCES-1:0] req_s, lowest_s, rise_s, claim_clr_s, w1c_s, pending_nxt_s;
    logic [4:0]             winner_s;
    logic                   access_s, claim_s, complete_s, wr_enable_s, wr_edge_s;
    logic [31:0]            rdata_nxt_s;
    logic                   unused_wdata_s;

    function automatic logic [4:0] lowest_id(input logic [NUM_SOURCES-1:0] req);
        logic [4:0] id;
        id = 5'd0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = 5'(i + 1);
            end else begin
                id = id;
            end
        end
        return id;
    endfunction

    assign req_s          = pending_r & enable_r;
    assign lowest_s       = req_s & (~req_s + LSB_ONE);
    assign winner_s       = lowest_id(req_s);
    assign rise_s         = s2_r & ~s2_d_r;
    assign claim_clr_s    = claim_s ? (lowest_s & edge_mode_r) : ALL_ZERO;
    // Edge sources: a new rise beats a same-cycle claim or W1C clear.
    assign pending_nxt_s  = (edge_mode_r & (rise_s | (pending_r & ~(claim_clr_s | w1c_s))))
                          | (~edge_mode_r & s2_r);
    assign unused_wdata_s = ^bus_wdata;

    assign bus_ready = bus_ready_r;
    assign bus_rdata = bus_rdata_r;
    assign ext_int   = ext_int_r;

    // Bus FSM next state and register access decode.
    always_comb begin
        state_nxt_s = state_r;
        access_s    = 1'b0;
        claim_s     = 1'b0;
        complete_s  = 1'b0;
        wr_enable_s = 1'b0;
        wr_edge_s   = 1'b0;
        w1c_s       = ALL_ZERO;
        rdata_nxt_s = 32'd0;
        case (state_r)
            ST_IDLE: begin
                if (bus_valid) begin
                    state_nxt_s = ST_RESP;
                    access_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
        if (access_s && bus_write) begin
            case (bus_addr)
                2'd0:    w1c_s       = bus_wdata[NUM_SOURCES-1:0] & edge_mode_r;
                2'd1:    wr_enable_s = 1'b1;
                2'd2:    wr_edge_s   = 1'b1;
                2'd3:    complete_s  = busy_r && (bus_wdata[4:0] == claimed_id_r);
                default: complete_s  = 1'b0;
            endcase
        end else if (access_s) begin
            case (bus_addr)
                2'd0:    rdata_nxt_s = 32'(pending_r);
                2'd1:    rdata_nxt_s = 32'(enable_r);
                2'd2:    rdata_nxt_s = 32'(edge_mode_r);
                2'd3: begin
                    if (!busy_r && (winner_s != 5'd0)) begin
                        claim_s     = 1'b1;
                        rdata_nxt_s = 32'(winner_s);
                    end else begin
                        claim_s     = 1'b0;
                    end
                end
                default: rdata_nxt_s = 32'd0;
            endcase
        end else begin
            rdata_nxt_s = 32'd0;
        end
    end

    // Bus FSM state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            bus_ready_r <= 1'b0;
            bus_rdata_r <= 32'd0;
            ext_int_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            bus_ready_r <= access_s;
            bus_rdata_r <= rdata_nxt_s;
            ext_int_r   <= ~busy_r & (|req_s);
        end
    end

    // Two-flop synchroniser plus delay stage for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_r   <= ALL_ZERO;
            s2_r   <= ALL_ZERO;
            s2_d_r <= ALL_ZERO;
        end else begin
            s1_r   <= irq_src;
            s2_r   <= s1_r;
            s2_d_r <= s2_r;
        end
    end

    // Configuration, pending vector and service state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_r     <= ALL_ZERO;
            edge_mode_r  <= {NUM_SOURCES{1'b1}};
            pending_r    <= ALL_ZERO;
            busy_r       <= 1'b0;
            claimed_id_r <= 5'd0;
        end else begin
            pending_r <= pending_nxt_s;
            if (wr_enable_s) begin
                enable_r <= bus_wdata[NUM_SOURCES-1:0];
            end else begin
                enable_r <= enable_r;
            end
            if (wr_edge_s) begin
                edge_mode_r <= bus_wdata[NUM_SOURCES-1:0];
            end else begin
                edge_mode_r <= edge_mode_r;
            end
            if (claim_s) begin
                busy_r       <= 1'b1;
                claimed_id_r <= winner_s;
            end else if (complete_s) begin
                busy_r       <= 1'b0;
                claimed_id_r <= claimed_id_r;
            end else begin
                busy_r       <= busy_r;
                claimed_id_r <= claimed_id_r;
            end
        end
    end
endmodule

// File: tb/tb_irq_controller.sv
// Randomised and directed bench for irq_controller, checked every cycle
// against a behavioural model of the interrupt and bus rules.
module tb_irq_controller;
    localparam int N = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [N-1:0]  irq_src = 8'h00;
    logic          bus_valid = 1'b0;
    logic          bus_write = 1'b0;
    logic [1:0]    bus_addr = 2'd0;
    logic [31:0]   bus_wdata = 32'd0;
    logic          bus_ready;
    logic [31:0]   bus_rdata;
    logic          ext_int;

    int checks = 0;
    int errors = 0;

    // Model state: interrupt sample history (1, 2 and 3 edges ago) and register view.
    logic [N-1:0] hist1, hist2, hist3;
    logic [N-1:0] m_pend, m_en, m_edge;
    bit           m_busy, m_resp, m_ready, m_ext;
    logic [4:0]   m_cid;
    logic [31:0]  m_rdata;
    logic [31:0]  rd;

    irq_controller #(.NUM_SOURCES(N)) dut (
        .clk(clk), .reset(reset), .irq_src(irq_src),
        .bus_valid(bus_valid), .bus_write(bus_write), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
        .ext_int(ext_int)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic model_reset();
        hist1 = 8'h00; hist2 = 8'h00; hist3 = 8'h00;
        m_pend = 8'h00; m_en = 8'h00; m_edge = 8'hFF;
        m_busy = 1'b0; m_cid = 5'd0; m_resp = 1'b0;
        m_ready = 1'b0; m_rdata = 32'd0; m_ext = 1'b0;
    endtask

    task automatic model_edge();
        logic [N-1:0] req, rise, clr, pend_n, en_n, edge_n;
        logic [4:0]   win, cid_n;
        logic [31:0]  rdv;
        bit           busy_n, exec;
        req = m_pend & m_en;
        win = 5'd0;
        for (int i = N - 1; i >= 0; i--) if (req[i]) win = 5'(i + 1);
        rise = hist2 & ~hist3;
        clr = 8'h00; en_n = m_en; edge_n = m_edge;
        busy_n = m_busy; cid_n = m_cid; rdv = 32'd0;
        exec = !m_resp && bus_valid;
        if (exec && bus_write) begin
            case (bus_addr)
                2'd0: clr = bus_wdata[N-1:0] & m_edge;
                2'd1: en_n = bus_wdata[N-1:0];
                2'd2: edge_n = bus_wdata[N-1:0];
                default: if (m_busy && bus_wdata[4:0] == m_cid) busy_n = 1'b0;
            endcase
        end else if (exec) begin
            case (bus_addr)
                2'd0: rdv = {24'd0, m_pend};
                2'd1: rdv = {24'd0, m_en};
                2'd2: rdv = {24'd0, m_edge};
                default: if (!m_busy && win != 5'd0) begin
                    rdv = {27'd0, win};
                    busy_n = 1'b1;
                    cid_n = win;
                    if (m_edge[win - 5'd1]) clr[win - 5'd1] = 1'b1;
                end
            endcase
        end
        for (int i = 0; i < N; i++)
            pend_n[i] = m_edge[i] ? (rise[i] | (m_pend[i] & !clr[i])) : hist2[i];
        m_ext = !m_busy && (req != 8'h00);
        m_ready = exec; m_rdata = rdv; m_resp = exec;
        m_pend = pend_n; m_en = en_n; m_edge = edge_n; m_busy = busy_n; m_cid = cid_n;
        hist3 = hist2; hist2 = hist1; hist1 = irq_src;
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_reset(); else model_edge();
        #1;
        check_val("ext_int", 32'(ext_int), 32'(m_ext));
        check_val("bus_ready", 32'(bus_ready), 32'(m_ready));
        check_val("bus_rdata", bus_rdata, m_rdata);
    endtask

    task automatic bus_access(input bit w, input logic [1:0] a, input logic [31:0] d,
                              output logic [31:0] rdv);
        bus_valid = 1'b1; bus_write = w; bus_addr = a; bus_wdata = d;
        step();
        rdv = bus_rdata;
        check_val("access_ready", 32'(bus_ready), 32'd1);
        bus_valid = 1'b0; bus_write = 1'b0;
        step();
    endtask

    initial begin
        model_reset();
        #1 reset = 1'b1;
        #1;
        check_val("init_rst_ext", 32'(ext_int), 32'd0);
        check_val("init_rst_ready", 32'(bus_ready), 32'd0);
        step(); step();
        reset = 1'b0;
        bus_access(1'b0, 2'd2, 32'd0, rd); check_val("edge_mode_reset", rd, 32'h000000FF);

        // Edge latch and claim/complete of source 3.
        bus_access(1'b1, 2'd1, 32'h04, rd);
        irq_src[2] = 1'b1;
        step(); step(); step();
        check_val("ext_before_e4", 32'(ext_int), 32'd0);
        irq_src[2] = 1'b0;
        step();
        check_val("ext_at_e4", 32'(ext_int), 32'd1);
        bus_access(1'b0, 2'd3, 32'd0, rd); check_val("claim3", rd, 32'd3);
        check_val("ext_drop_claim", 32'(ext_int), 32'd0);
        bus_access(1'b0, 2'd0, 32'd0, rd); check_val("pend_after_claim", rd, 32'd0);
        bus_access(1'b1, 2'd3, 32'd3, rd);
        step();
        check_val("ext_after_complete3", 32'(ext_int), 32'd0);

        // Priority between two simultaneous edge sources.
        bus_access(1'b1, 2'd1, 32'hFF, rd);
        irq_src = 8'h22;
        step(); step(); step();
        irq_src = 8'h00;
        step(); step(); step();
        bus_access(1'b0, 2'd3, 32'd0, rd); check_val("claim_prio", rd, 32'd2);
        bus_access(1'b1, 2'd3, 32'd2, rd); check_val("ext_rerise", 32'(ext_int), 32'd1);
        bus_access(1'b0, 2'd3, 32'd0, rd); check_val("claim_second", rd, 32'd6);
        bus_access(1'b1, 2'd3, 32'd6, rd);

        // Level mode tracking and completion filtering.
        bus_access(1'b1, 2'd2, 32'h00, rd);
        irq_src[0] = 1'b1;
        step(); step(); step(); step();
        bus_access(1'b0, 2'd3, 32'd0, rd); check_val("claim_level", rd, 32'd1);
        bus_access(1'b0, 2'd0, 32'd0, rd); check_val("pend_level", rd, 32'd1);
        bus_access(1'b1, 2'd3, 32'd4, rd);
        step();
        check_val("ext_wrong_complete", 32'(ext_int), 32'd0);
        bus_access(1'b1, 2'd3, 32'd1, rd); check_val("ext_level_reassert", 32'(ext_int), 32'd1);
        irq_src[0] = 1'b0;
        step(); step(); step(); step();
        bus_access(1'b1, 2'd2, 32'hFF, rd);
        bus_access(1'b1, 2'd0, 32'hFF, rd);

        // Claim and a fresh rise hit pending bit 0 on the same edge.
        irq_src[0] = 1'b1; step(); step();
        irq_src[0] = 1'b0; step(); step();
        irq_src[0] = 1'b1; step(); step();
        irq_src[0] = 1'b0;
        bus_access(1'b0, 2'd3, 32'd0, rd); check_val("claim_collision", rd, 32'd1);
        bus_access(1'b0, 2'd0, 32'd0, rd); check_val("pend_collision", rd, 32'd1);
        bus_access(1'b0, 2'd3, 32'd0, rd); check_val("claim_busy", rd, 32'd0);
        bus_access(1'b1, 2'd3, 32'd1, rd);

        // Back-to-back reads with bus_valid held.
        bus_valid = 1'b1; bus_write = 1'b0; bus_addr = 2'd1;
        for (int k = 0; k < 5; k++) begin
            step();
            check_val("ready_pattern", 32'(bus_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
        end
        bus_valid = 1'b0;
        step();

        // Randomised traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(3) == 0) irq_src[$urandom_range(N - 1)] ^= 1'b1;
            bus_valid = ($urandom_range(2) == 0);
            bus_write = 1'($urandom_range(1));
            bus_addr  = 2'($urandom_range(3));
            bus_wdata = $urandom;
            if (bus_addr == 2'd3 && $urandom_range(3) != 0) bus_wdata = {27'd0, m_cid};
            step();
        end
        bus_valid = 1'b0;
        step();
        if (m_resp) step();

        // Asynchronous reset in the middle of a response cycle.
        irq_src = 8'hFF;
        bus_valid = 1'b1; bus_write = 1'b0; bus_addr = 2'd2;
        step();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_val("rst_ready", 32'(bus_ready), 32'd0);
        check_val("rst_rdata", bus_rdata, 32'd0);
        check_val("rst_ext", 32'(ext_int), 32'd0);
        bus_valid = 1'b0;
        step(); step();
        reset = 1'b0;
        bus_access(1'b0, 2'd2, 32'd0, rd); check_val("edge_after_reset", rd, 32'h000000FF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
